// File: rtl/saturn_nibble_mem.sv
// ---------------------------------------------------------------------------
// saturn_nibble_mem
//   Nibble-wide RAM responder for a burst request bus.
//
//   The RAM covers 2**RAM_AW nibbles starting at RAM_BASE. The 20-bit
//   address space wraps, so the window test is done on the modular
//   offset from RAM_BASE. Accesses outside the window still complete
//   every handshake: reads return 0, writes are dropped, and err is set.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     req_valid/req_ready   burst request handshake
//     req_write             1 = write burst, 0 = read burst
//     req_addr[19:0]        start nibble address
//     req_len[3:0]          burst length minus one
//     wr_valid/wr_ready     write nibble handshake, data on wr_nibble[3:0]
//     rd_valid/rd_ready     read nibble handshake, data on rd_nibble[3:0]
//     rd_last               current read nibble ends the burst
//     busy                  a burst is in progress
//     err                   sticky out-of-window flag, cleared on acceptance
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for a request, req_ready=1
//   RD_FETCH | synchronous array read at the current address
//   RD_DATA  | fetched nibble presented, waiting for rd_ready
//   WR_DATA  | accepting write nibbles, wr_ready=1
// ---------------------------------------------------------------------------
module saturn_nibble_mem #(
  parameter logic [19:0] RAM_BASE = 20'h80000,
  parameter int          RAM_AW   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [19:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic        wr_valid,
  input  logic [3:0]  wr_nibble,
  output logic        wr_ready,
  output logic        rd_valid,
  output logic [3:0]  rd_nibble,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_FETCH = 2'd1,
    RD_DATA  = 2'd2,
    WR_DATA  = 2'd3
  } state_t;

  state_t             state;
  logic [19:0]        addr;
  logic [3:0]         cnt;
  logic               rd_oow;
  logic [3:0]         mem [DEPTH];

  logic [19:0]        off;
  logic               in_win;
  logic [RAM_AW-1:0]  idx;
  logic               wr_fire;

  // Modular offset: addresses below RAM_BASE wrap to large offsets and so
  // fall outside the window without a separate lower-bound compare.
  assign off    = addr - RAM_BASE;
  assign in_win = (off >> RAM_AW) == 20'd0;
  assign idx    = off[RAM_AW-1:0];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rd_valid  = (state == RD_DATA);
  assign wr_ready  = (state == WR_DATA);
  assign rd_last   = (state == RD_DATA) && (cnt == 4'd0);

  assign wr_fire = (state == WR_DATA) && wr_valid;

  // Array has no reset so contents survive it; reset only blocks the write
  // so a burst aborted by reset cannot land one more nibble.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire && in_win) begin
      mem[idx] <= wr_nibble;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= 20'd0;
      cnt       <= 4'd0;
      rd_nibble <= 4'd0;
      rd_oow    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr  <= req_addr;
            cnt   <= req_len;
            err   <= 1'b0;
            state <= req_write ? WR_DATA : RD_FETCH;
          end
        end
        RD_FETCH: begin
          rd_nibble <= in_win ? mem[idx] : 4'h0;
          // Remember the window result so err rises on the read handshake.
          rd_oow    <= !in_win;
          state     <= RD_DATA;
        end
        RD_DATA: begin
          if (rd_ready) begin
            if (rd_oow) begin
              err <= 1'b1;
            end
            if (cnt == 4'd0) begin
              state <= IDLE;
            end else begin
              addr  <= addr + 20'd1;
              cnt   <= cnt - 4'd1;
              state <= RD_FETCH;
            end
          end
        end
        WR_DATA: begin
          if (wr_valid) begin
            if (!in_win) begin
              err <= 1'b1;
            end
            addr <= addr + 20'd1;
            if (cnt == 4'd0) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_nibble_mem.sv
module tb_saturn_nibble_mem;

  localparam logic [19:0] BASE = 20'h80000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [19:0] req_addr;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_nibble;
  logic        rd_valid, rd_last, rd_ready;
  logic [3:0]  rd_nibble;
  logic        busy, err;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem_m [4096];

  saturn_nibble_mem #(.RAM_BASE(20'h80000), .RAM_AW(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_nibble(wr_nibble), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_nibble(rd_nibble), .rd_last(rd_last),
    .rd_ready(rd_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", nm);
  endtask

  function automatic bit in_win(input logic [19:0] a);
    logic [19:0] o;
    o = a - BASE;
    return o < 20'd4096;
  endfunction

  function automatic logic [11:0] offs(input logic [19:0] a);
    logic [19:0] o;
    o = a - BASE;
    return o[11:0];
  endfunction

  task automatic issue(input bit w, input logic [19:0] a, input logic [3:0] len, output bit ok);
    int t;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = len;
    t = 0;
    while (!req_ready && t < 50) begin step; t++; end
    ok = req_ready;
    if (!ok) timeout("req_accept");
    step;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic wr_burst(input logic [19:0] a, input logic [3:0] len, input logic [63:0] d,
                          input bit gaps);
    int t;
    bit ok, e;
    logic [19:0] aa;
    issue(1'b1, a, len, ok);
    if (!ok) return;
    e = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin rd_ready = 1'($urandom); step; end
      rd_ready = 1'b0;
      wr_valid = 1'b1; wr_nibble = d[i*4 +: 4];
      t = 0;
      while (!wr_ready && t < 20) begin step; t++; end
      if (!wr_ready) begin timeout("wr_handshake"); wr_valid = 1'b0; return; end
      step;
      wr_valid = 1'b0; wr_nibble = 4'($urandom);
      aa = a + 20'(i);
      if (in_win(aa)) mem_m[offs(aa)] = d[i*4 +: 4];
      else e = 1'b1;
    end
    chk("wr_done_req_ready", 64'(req_ready), 64'd1);
    chk("wr_done_busy", 64'(busy), 64'd0);
    chk("wr_err", 64'(err), 64'(e));
  endtask

  // Data phase of a read burst, entered in the cycle right after acceptance.
  task automatic rd_phase(input logic [19:0] a, input logic [3:0] len, input int stall_at,
                          input int stall_n, input bit rnd, output logic [63:0] got,
                          output bit e);
    int t, n;
    logic [19:0] aa;
    logic [3:0] exp;
    got = 64'd0;
    e = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == 0) chk("rd_not_valid_yet", 64'(rd_valid), 64'd0);
      t = 0;
      while (!rd_valid && t < 8) begin
        wr_valid = 1'($urandom); wr_nibble = 4'($urandom);
        step; t++;
      end
      wr_valid = 1'b0;
      if (!rd_valid) begin timeout("rd_valid"); return; end
      if (i == 0) chk("rd_latency", 64'(t), 64'd1);
      aa = a + 20'(i);
      exp = in_win(aa) ? mem_m[offs(aa)] : 4'h0;
      if (!in_win(aa)) e = 1'b1;
      chk("rd_data", 64'(rd_nibble), 64'(exp));
      chk("rd_last", 64'(rd_last), 64'(i == int'(len)));
      chk("rd_req_ready_low", 64'(req_ready), 64'd0);
      n = (i == stall_at) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      repeat (n) begin
        rd_ready = 1'b0;
        step;
        chk("rd_hold_valid", 64'(rd_valid), 64'd1);
        chk("rd_hold_data", 64'(rd_nibble), 64'(exp));
        chk("rd_hold_last", 64'(rd_last), 64'(i == int'(len)));
      end
      got[i*4 +: 4] = rd_nibble;
      rd_ready = 1'b1;
      step;
      rd_ready = 1'b0;
    end
  endtask

  task automatic rd_burst(input logic [19:0] a, input logic [3:0] len, input int stall_at,
                          input int stall_n, input bit rnd, output logic [63:0] got);
    bit ok, e;
    got = 64'd0;
    issue(1'b0, a, len, ok);
    if (!ok) return;
    rd_phase(a, len, stall_at, stall_n, rnd, got, e);
    chk("rd_done_req_ready", 64'(req_ready), 64'd1);
    chk("rd_done_busy", 64'(busy), 64'd0);
    chk("rd_err", 64'(err), 64'(e));
  endtask

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [3:0]  len;
    logic [63:0] data;
    bit          exp_err;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [63:0] got, d;
    logic [19:0] a;
    logic [3:0]  len;
    bit ok, e;

    vt[0] = '{1'b1, 20'h80000, 4'd3, 64'h4321, 1'b0};
    vt[1] = '{1'b0, 20'h80000, 4'd3, 64'h4321, 1'b0};
    vt[2] = '{1'b1, 20'h80FFF, 4'd1, 64'hBA,   1'b1};
    vt[3] = '{1'b0, 20'h80FFF, 4'd0, 64'hA,    1'b0};
    vt[4] = '{1'b0, 20'hFFFFF, 4'd1, 64'h00,   1'b1};
    vt[5] = '{1'b0, 20'h7FFFF, 4'd1, 64'h10,   1'b1};
    vt[6] = '{1'b1, 20'h7FFFE, 4'd2, 64'h765,  1'b1};
    vt[7] = '{1'b0, 20'h80000, 4'd0, 64'h7,    1'b0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 20'd0; req_len = 4'd0;
    wr_valid = 1'b0; wr_nibble = 4'd0; rd_ready = 1'b0;
    repeat (3) step;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_rd_nibble", 64'(rd_nibble), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b0;
    step;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Fill the whole window so every later read has a known value.
    for (int b = 0; b < 256; b++) begin
      d = {$urandom, $urandom};
      wr_burst(BASE + 20'(b * 16), 4'd15, d, 1'b1);
    end

    for (int v = 0; v < 8; v++) begin
      if (vt[v].wr) begin
        wr_burst(vt[v].addr, vt[v].len, vt[v].data, 1'b0);
      end else begin
        rd_burst(vt[v].addr, vt[v].len, -1, 0, 1'b0, got);
        chk("vec_rd_data", got, vt[v].data);
      end
      chk("vec_err", 64'(err), 64'(vt[v].exp_err));
    end

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: a = BASE + 20'($urandom_range(0, 4095));
        1: a = BASE + 20'($urandom_range(4085, 4095));
        2: a = BASE - 20'($urandom_range(1, 10));
        default: a = 20'hFFFF0 + 20'($urandom_range(0, 15));
      endcase
      len = 4'($urandom);
      if ($urandom_range(0, 1) == 1) wr_burst(a, len, {$urandom, $urandom}, 1'b1);
      else rd_burst(a, len, -1, 0, 1'b1, got);
    end

    // Long stall on the 2nd nibble of a read burst.
    rd_burst(20'h80040, 4'd3, 1, 5, 1'b0, got);

    // Request held across two read bursts.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h80100; req_len = 4'd2;
    begin
      int t;
      t = 0;
      while (!req_ready && t < 50) begin step; t++; end
      if (!req_ready) timeout("b2b_first_accept");
    end
    step;
    req_addr = 20'h80123; req_len = 4'd1;
    rd_phase(20'h80100, 4'd2, -1, 0, 1'b0, got, e);
    chk("b2b_req_ready_first_idle", 64'(req_ready), 64'd1);
    step;
    chk("b2b_second_accepted", 64'(busy), 64'd1);
    rd_phase(20'h80123, 4'd1, -1, 0, 1'b0, got, e);
    req_valid = 1'b0;
    chk("b2b_done", 64'(req_ready), 64'd1);

    // Reset while the 3rd nibble of a 16-nibble write is on the bus.
    a = 20'h80200;
    issue(1'b1, a, 4'd15, ok);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_nibble = 4'(i + 9);
      chk("rst_burst_wr_ready", 64'(wr_ready), 64'd1);
      step;
      mem_m[offs(a + 20'(i))] = 4'(i + 9);
    end
    wr_nibble = ~mem_m[offs(a + 20'd2)];
    reset = 1'b1;
    repeat (3) begin
      step;
      wr_nibble = ~mem_m[offs(a + 20'd3)];
    end
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wr_ready", 64'(wr_ready), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
    reset = 1'b0;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    step;
    chk("midrst_still_idle", 64'(busy), 64'd0);
    wr_valid = 1'b0;
    rd_burst(a, 4'd15, -1, 0, 1'b0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
